r_peak_detector_fsm: RTL and testbench

//  Parametrised ECG R-peak detector, successor of the single-threshold slope detector.
//  - Computes the first difference of the filtered ECG stream.
//  - Qualifies each QRS as a positive slope followed by a negative slope.
//  - Enforces a programmable refractory period and reports peak amplitude and RR interval.
//  - Sits after the band-pass/diff stage; feeds the heart-rate/HRV logic.

---
 rtl/r_peak_detector_fsm.sv | 131 +++++++++++++
 tb/tb_r_peak_detector_fsm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_peak_detector_fsm.sv
// ECG R-peak detector: registered first difference of the sample stream, then a
// rise/fall qualifier FSM with refractory hold, peak amplitude and RR interval.
module r_peak_detector_fsm #(
    parameter int DATA_W  = 12,
    parameter int CNT_W   = 12,
    parameter int MAX_QRS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   d_in,
    input  logic [DATA_W-1:0]   thr_pos,
    input  logic [DATA_W-1:0]   thr_neg,
    input  logic [CNT_W-1:0]    refract,
    output logic [DATA_W:0]     diff,
    output logic                slope,
    output logic                r_peak,
    output logic [DATA_W-1:0]   peak_amp,
    output logic [CNT_W-1:0]    rr_int,
    output logic                rr_valid
);

    localparam int QC_W = $clog2(MAX_QRS + 1);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(MAX_QRS - 1);

    typedef enum logic [1:0] {SEARCH, RISE, REFRACT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   prev;
    logic                first_flag;
    logic                diff_vld;
    logic [DATA_W-1:0]   amp;
    logic [QC_W-1:0]     qc;
    logic [CNT_W-1:0]    sc;
    logic [CNT_W-1:0]    sc_inc;
    logic [CNT_W-1:0]    rc;
    logic                have_peak;

    logic signed [DATA_W+1:0] diff_x;
    logic signed [DATA_W+1:0] pos_x;
    logic signed [DATA_W+1:0] neg_x;
    logic                     rise_hit;
    logic                     fall_hit;

    // Stage 1: prev holds the sample that produced the current diff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            diff       <= '0;
            diff_vld   <= 1'b0;
            first_flag <= 1'b1;
        end else begin
            diff_vld <= 1'b0;
            if (s_valid) begin
                prev <= d_in;
                if (first_flag) begin
                    diff       <= '0;
                    first_flag <= 1'b0;
                end else begin
                    diff     <= {1'b0, d_in} - {1'b0, prev};
                    diff_vld <= 1'b1;
                end
            end
        end
    end

    // Compare in DATA_W+2 bits so -thr_neg and the signed diff both fit.
    assign diff_x   = {diff[DATA_W], diff};
    assign pos_x    = $signed({2'b00, thr_pos});
    assign neg_x    = -$signed({2'b00, thr_neg});
    assign rise_hit = (diff_x >= pos_x);
    assign fall_hit = (diff_x <= neg_x);
    assign slope    = rise_hit | fall_hit;

    assign sc_inc = (sc == '1) ? sc : sc + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            amp       <= '0;
            qc        <= '0;
            sc        <= '0;
            rc        <= '0;
            have_peak <= 1'b0;
            r_peak    <= 1'b0;
            rr_valid  <= 1'b0;
            peak_amp  <= '0;
            rr_int    <= '0;
        end else begin
            r_peak   <= 1'b0;
            rr_valid <= 1'b0;
            if (diff_vld) begin
                sc <= sc_inc;
                case (state)
                    SEARCH: begin
                        if (rise_hit) begin
                            state <= RISE;
                            amp   <= prev;
                            qc    <= '0;
                        end
                    end
                    RISE: begin
                        amp <= (prev > amp) ? prev : amp;
                        qc  <= qc + 1'b1;
                        if (fall_hit) begin
                            r_peak    <= 1'b1;
                            rr_valid  <= have_peak;
                            have_peak <= 1'b1;
                            peak_amp  <= amp;
                            // Interval includes the detecting sample itself.
                            rr_int    <= sc_inc;
                            sc        <= '0;
                            rc        <= '0;
                            state     <= REFRACT;
                        end else if (qc == QC_LAST) begin
                            state <= SEARCH;
                        end
                    end
                    REFRACT: begin
                        rc <= rc + 1'b1;
                        if (refract == '0 || rc == refract - 1'b1) begin
                            state <= SEARCH;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_r_peak_detector_fsm.sv
// Directed bench for r_peak_detector_fsm: reset, single QRS, RR interval,
// refractory rejection, QRS abandon boundary, input gaps and RR saturation.
module tb_r_peak_detector_fsm;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] thr_pos;
    logic [DATA_W-1:0] thr_neg;
    logic [CNT_W-1:0]  refract;
    logic [DATA_W:0]   diff;
    logic              slope;
    logic              r_peak;
    logic [DATA_W-1:0] peak_amp;
    logic [CNT_W-1:0]  rr_int;
    logic              rr_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_send_cyc;
    int peak_cnt = 0;
    int peak_cyc = 0;
    int got_amp = 0;
    int got_rr = 0;
    int got_rrv = 0;

    r_peak_detector_fsm #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_QRS(40)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .d_in(d_in),
        .thr_pos(thr_pos), .thr_neg(thr_neg), .refract(refract),
        .diff(diff), .slope(slope), .r_peak(r_peak), .peak_amp(peak_amp),
        .rr_int(rr_int), .rr_valid(rr_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peak monitor: captures the pulse and its payload away from the active edge.
    always @(negedge clk) begin
        if (r_peak === 1'b1) begin
            peak_cnt = peak_cnt + 1;
            peak_cyc = cyc;
            got_amp  = int'(peak_amp);
            got_rr   = int'(rr_int);
            got_rrv  = int'(rr_valid);
        end
    end

    task automatic send(input int x);
        @(negedge clk);
        s_valid       = 1'b1;
        d_in          = DATA_W'(x);
        last_send_cyc = cyc;
    endtask

    task automatic send_n(input int x, input int n);
        for (int i = 0; i < n; i++) send(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (diff !== '0 || slope !== 1'b0 || r_peak !== 1'b0 || peak_amp !== '0 ||
            rr_int !== '0 || rr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial diff=%0d slope=%0b r_peak=%0b amp=%0d rr=%0d rrv=%0b, want all 0",
                     diff, slope, r_peak, peak_amp, rr_int, rr_valid);
        end
        rst = 1'b0;
        send(100);
        send(140);
        send(200);
        idle(1);
        checks++;
        if (diff !== 13'sd60 || slope !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_diff got diff=%0d slope=%0b want 60/1", $signed(diff), slope);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (diff !== '0 || slope !== 1'b0 || r_peak !== 1'b0 || peak_amp !== '0 ||
            rr_int !== '0 || rr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async diff=%0d slope=%0b r_peak=%0b amp=%0d rr=%0d rrv=%0b, want all 0",
                     diff, slope, r_peak, peak_amp, rr_int, rr_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        send(500);
        idle(1);
        checks++;
        if (diff !== '0 || slope !== 1'b0) begin
            errors++;
            $display("FAIL first_sample_after_reset diff=%0d slope=%0b want 0/0", $signed(diff), slope);
        end
    endtask

    // Diffs 0,30,40,-20,...; -20 already meets thr_neg=20, so the sample 150 completes the QRS.
    task automatic test_single_qrs();
        int base;
        int c150;
        do_reset();
        base = peak_cnt;
        send(100);
        send(100);
        send(130);
        send(170);
        checks++;
        if ($signed(diff) !== 13'sd30 || slope !== 1'b1) begin
            errors++;
            $display("FAIL single_rise_diff got diff=%0d slope=%0b want 30/1", $signed(diff), slope);
        end
        send(150);
        c150 = last_send_cyc;
        send(110);
        send(100);
        idle(4);
        checks++;
        if (peak_cnt - base !== 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", peak_cnt - base);
        end
        checks++;
        if (peak_cyc !== c150 + 2) begin
            errors++;
            $display("FAIL single_latency got cycle %0d want %0d", peak_cyc, c150 + 2);
        end
        checks++;
        if (got_amp !== 170 || got_rrv !== 0 || got_rr !== 4) begin
            errors++;
            $display("FAIL single_payload amp=%0d rrv=%0d rr=%0d want 170/0/4", got_amp, got_rrv, got_rr);
        end
    endtask

    // Continues from the single QRS: its falling sample was 2 samples before this task.
    task automatic test_two_qrs();
        int base;
        base = peak_cnt;
        send_n(100, 295);
        send(130);
        send(200);
        send(180);
        send(100);
        idle(4);
        checks++;
        if (peak_cnt - base !== 1) begin
            errors++;
            $display("FAIL two_qrs_count got %0d want 1", peak_cnt - base);
        end
        checks++;
        if (got_rr !== 300 || got_rrv !== 1 || got_amp !== 200) begin
            errors++;
            $display("FAIL two_qrs_payload rr=%0d rrv=%0d amp=%0d want 300/1/200", got_rr, got_rrv, got_amp);
        end
    endtask

    // Second QRS falls 50 samples after the previous peak, inside refract=100.
    task automatic test_refract_reject();
        int base;
        base = peak_cnt;
        send_n(100, 46);
        send(130);
        send(200);
        send(180);
        send_n(100, 150);
        idle(4);
        checks++;
        if (peak_cnt - base !== 0) begin
            errors++;
            $display("FAIL refract_reject got %0d peaks want 0", peak_cnt - base);
        end
    endtask

    task automatic test_abandon();
        int base;
        int cfall;
        base = peak_cnt;
        send(150);
        send_n(150, 40);
        send(100);
        idle(4);
        checks++;
        if (peak_cnt - base !== 0) begin
            errors++;
            $display("FAIL abandon_40_flat got %0d peaks want 0", peak_cnt - base);
        end
        send_n(100, 5);
        send(150);
        send_n(150, 39);
        send(100);
        cfall = last_send_cyc;
        idle(4);
        checks++;
        if (peak_cnt - base !== 1 || peak_cyc !== cfall + 2) begin
            errors++;
            $display("FAIL abandon_39_flat peaks=%0d cyc=%0d want 1 at %0d", peak_cnt - base, peak_cyc, cfall + 2);
        end
        checks++;
        if (got_amp !== 150 || got_rrv !== 1) begin
            errors++;
            $display("FAIL abandon_39_payload amp=%0d rrv=%0d want 150/1", got_amp, got_rrv);
        end
    endtask

    // Same waveform as the single QRS, with two idle cycles after every sample.
    task automatic test_gaps_and_saturation();
        int base;
        int c150;
        int vals[7];
        vals = '{100, 100, 130, 170, 150, 110, 100};
        do_reset();
        base = peak_cnt;
        for (int i = 0; i < 7; i++) begin
            send(vals[i]);
            if (i == 4) c150 = last_send_cyc;
            idle(2);
        end
        idle(3);
        checks++;
        if (peak_cnt - base !== 1 || got_amp !== 170 || got_rrv !== 0) begin
            errors++;
            $display("FAIL gaps_peak peaks=%0d amp=%0d rrv=%0d want 1/170/0", peak_cnt - base, got_amp, got_rrv);
        end
        checks++;
        if (peak_cyc !== c150 + 2) begin
            errors++;
            $display("FAIL gaps_latency got cycle %0d want %0d", peak_cyc, c150 + 2);
        end
        base = peak_cnt;
        send_n(100, 5000);
        send(130);
        send(200);
        send(180);
        send(100);
        idle(4);
        checks++;
        if (peak_cnt - base !== 1 || got_rr !== 4095 || got_rrv !== 1 || got_amp !== 200) begin
            errors++;
            $display("FAIL rr_saturate peaks=%0d rr=%0d rrv=%0d amp=%0d want 1/4095/1/200",
                     peak_cnt - base, got_rr, got_rrv, got_amp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        d_in    = '0;
        thr_pos = 12'd20;
        thr_neg = 12'd20;
        refract = 12'd100;
        test_reset();
        test_single_qrs();
        test_two_qrs();
        test_refract_reject();
        test_abandon();
        test_gaps_and_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
